// File: rtl/ama_riscv_dmem_resp.sv
// Data-memory responder: byte-writable synchronous word array with stores in the
// request cycle and registered, aligned, sign/zero-extended load data.
module ama_riscv_dmem_resp #(
    parameter int ADDR_W = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        en,
    input  logic [3:0]  we,
    input  logic        load_sm_en,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] rdata_raw,
    output logic        misaligned
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] word_idx_s;
    logic [1:0]        off_s;
    logic              mis_s;
    logic              is_load_s;
    logic [3:0]        wr_lanes_s;
    logic [31:0]       wdata_sh_s;
    logic              unused_addr_s;

    logic [31:0]       rdata_raw_d, rdata_raw_q;
    logic              misaligned_d, misaligned_q;
    logic [2:0]        funct3_d, funct3_q;
    logic [1:0]        off_d, off_q;
    logic              load_sm_en_d, load_sm_en_q;

    logic [31:0]       shifted_s;
    logic [31:0]       rdata_s;

    assign word_idx_s    = addr[ADDR_W+1:2];
    assign off_s         = addr[1:0];
    assign unused_addr_s = ^addr[31:ADDR_W+2];
    assign wdata_sh_s    = wdata << {off_s, 3'b000};

    // Access decode: alignment check, load detection and store lane gating
    always_comb begin
        case (funct3[1:0])
            2'b01:   mis_s = off_s[0];
            2'b10:   mis_s = (off_s != 2'b00);
            default: mis_s = 1'b0;
        endcase
        is_load_s = en && (we == 4'b0000) && !mis_s;
        if (!rst && !stall && en && !mis_s) begin
            wr_lanes_s = we;
        end else begin
            wr_lanes_s = 4'b0000;
        end
    end

    // Byte-lane writes into the array; contents are never reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_lanes_s[i]) begin
                mem[word_idx_s][8*i +: 8] <= wdata_sh_s[8*i +: 8];
            end
        end
    end

    // Next-state of the output registers; stall holds everything
    always_comb begin
        rdata_raw_d  = rdata_raw_q;
        misaligned_d = misaligned_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        load_sm_en_d = load_sm_en_q;
        if (!stall) begin
            // Non-load cycles clear the data so stale words never reach writeback
            rdata_raw_d  = is_load_s ? mem[word_idx_s] : 32'h0000_0000;
            misaligned_d = en && mis_s;
            funct3_d     = funct3;
            off_d        = off_s;
            load_sm_en_d = load_sm_en;
        end else begin
            rdata_raw_d  = rdata_raw_q;
        end
    end

    // Output registers with synchronous reset taking priority over stall
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_raw_q  <= 32'h0000_0000;
            misaligned_q <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            load_sm_en_q <= 1'b0;
        end else begin
            rdata_raw_q  <= rdata_raw_d;
            misaligned_q <= misaligned_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            load_sm_en_q <= load_sm_en_d;
        end
    end

    assign shifted_s = rdata_raw_q >> {off_q, 3'b000};

    // Load alignment and extension from registered state only
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (!load_sm_en_q) begin
            rdata_s = rdata_raw_q;
        end else begin
            case (funct3_q)
                3'b000:  rdata_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
                3'b001:  rdata_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
                3'b010:  rdata_s = rdata_raw_q;
                3'b100:  rdata_s = {24'h00_0000, shifted_s[7:0]};
                3'b101:  rdata_s = {16'h0000, shifted_s[15:0]};
                default: rdata_s = 32'h0000_0000;
            endcase
        end
    end

    assign rdata      = rdata_s;
    assign rdata_raw  = rdata_raw_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_ama_riscv_dmem_resp.sv
// Bench for ama_riscv_dmem_resp: directed plan steps plus random traffic checked
// against a byte-addressed reference memory.
module tb_ama_riscv_dmem_resp;

    localparam int ADDR_W = 14;
    localparam int unsigned BYTE_SPAN = 32'd1 << (ADDR_W + 2);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  we = 4'h0;
    logic        load_sm_en = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic [31:0] rdata_raw;
    logic        misaligned;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_m [int unsigned];
    logic [31:0] exp_rdata = 32'h0;
    logic [31:0] exp_raw = 32'h0;
    logic        exp_mis = 1'b0;

    ama_riscv_dmem_resp #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .en(en), .we(we),
        .load_sm_en(load_sm_en), .funct3(funct3), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rdata_raw(rdata_raw), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int unsigned base;
        logic [31:0] w;
        base = (a % BYTE_SPAN) / 4 * 4;
        w = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (mem_m.exists(base + i)) w = w + (32'(mem_m[base + i]) << (8 * i));
        end
        return w;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] f3,
                                           input int unsigned off, input logic sm);
        logic [31:0] v;
        if (!sm) return w;
        v = w >> (8 * off);
        case (f3)
            3'd0: begin v = v % 32'd256;   if (v >= 32'd128)   v = v + 32'hFFFF_FF00; end
            3'd4: v = v % 32'd256;
            3'd1: begin v = v % 32'd65536; if (v >= 32'd32768) v = v + 32'hFFFF_0000; end
            3'd5: v = v % 32'd65536;
            3'd2: v = w;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // One cycle of traffic: drive, predict, clock, compare
    task automatic step(input string tag, input logic e, input logic [3:0] w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic sm, input logic st);
        int unsigned size, off, base;
        logic mis;
        logic [31:0] sh;
        en = e; we = w; funct3 = f3; addr = a; wdata = d; load_sm_en = sm; stall = st; rst = 1'b0;
        if (!st) begin
            size = 32'd1 << f3[1:0];
            off  = a % 4;
            mis  = e && (size == 2 || size == 4) && (a % size != 0);
            exp_mis = mis;
            if (e && !mis && w == 4'h0) begin
                exp_raw   = model_word(a);
                exp_rdata = extend(exp_raw, f3, off, sm);
            end else begin
                exp_raw   = 32'h0;
                exp_rdata = 32'h0;
            end
            if (e && !mis && w != 4'h0) begin
                base = (a % BYTE_SPAN) / 4 * 4;
                sh = d << (8 * off);
                for (int i = 0; i < 4; i++)
                    if (w[i]) mem_m[base + i] = 8'((sh >> (8 * i)) % 32'd256);
            end
        end
        @(posedge clk); #1;
        chk({tag, ".rdata"}, rdata, exp_rdata);
        chk({tag, ".raw"}, rdata_raw, exp_raw);
        chk({tag, ".mis"}, {31'h0, misaligned}, {31'h0, exp_mis});
    endtask

    task automatic do_reset(input string tag, input logic e, input logic [3:0] w, input logic [31:0] a,
                            input logic [31:0] d, input logic st);
        en = e; we = w; funct3 = 3'd2; addr = a; wdata = d; load_sm_en = 1'b1; stall = st; rst = 1'b1;
        exp_rdata = 32'h0; exp_raw = 32'h0; exp_mis = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk({tag, ".rdata"}, rdata, 32'h0);
        chk({tag, ".raw"}, rdata_raw, 32'h0);
        chk({tag, ".mis"}, {31'h0, misaligned}, 32'h0);
    endtask

    initial begin
        logic [31:0] r, a, d;
        logic [2:0]  f3;
        logic [3:0]  w;
        logic [2:0]  f3_tab [8];
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

        #1;
        do_reset("reset0", 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

        // Word round-trip and a neighbour word
        step("sw100", 1'b1, 4'hF, 3'd2, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0);
        step("sw104", 1'b1, 4'hF, 3'd2, 32'h104, 32'h12345678, 1'b1, 1'b0);
        step("lw100", 1'b1, 4'h0, 3'd2, 32'h100, 32'h0, 1'b1, 1'b0);
        chk("lw100.const", rdata, 32'hDEADBEEF);

        // Stall with new requests: outputs hold, no writes
        step("stall1", 1'b1, 4'hF, 3'd2, 32'h100, 32'h11111111, 1'b1, 1'b1);
        step("stall2", 1'b1, 4'h0, 3'd0, 32'h103, 32'h0, 1'b1, 1'b1);
        step("stall3", 1'b1, 4'hF, 3'd2, 32'h104, 32'h22222222, 1'b1, 1'b1);
        chk("stall.const", rdata, 32'hDEADBEEF);
        step("lw100b", 1'b1, 4'h0, 3'd2, 32'h100, 32'h0, 1'b1, 1'b0);
        chk("lw100b.const", rdata, 32'hDEADBEEF);
        step("lw104", 1'b1, 4'h0, 3'd2, 32'h104, 32'h0, 1'b1, 1'b0);
        chk("lw104.const", rdata, 32'h12345678);

        // Byte lanes and sign
        step("sb103", 1'b1, 4'h8, 3'd0, 32'h103, 32'h80, 1'b1, 1'b0);
        chk("sb103.zero", rdata, 32'h0);
        step("lb103", 1'b1, 4'h0, 3'd0, 32'h103, 32'h0, 1'b1, 1'b0);
        chk("lb103.const", rdata, 32'hFFFFFF80);
        step("lbu103", 1'b1, 4'h0, 3'd4, 32'h103, 32'h0, 1'b1, 1'b0);
        chk("lbu103.const", rdata, 32'h00000080);
        step("lw100c", 1'b1, 4'h0, 3'd2, 32'h100, 32'h0, 1'b1, 1'b0);
        chk("lw100c.const", rdata, 32'h80ADBEEF);

        // Half-word
        step("sh102", 1'b1, 4'hC, 3'd1, 32'h102, 32'h8001, 1'b1, 1'b0);
        step("lh102", 1'b1, 4'h0, 3'd1, 32'h102, 32'h0, 1'b1, 1'b0);
        chk("lh102.const", rdata, 32'hFFFF8001);
        step("lhu102", 1'b1, 4'h0, 3'd5, 32'h102, 32'h0, 1'b1, 1'b0);
        chk("lhu102.const", rdata, 32'h00008001);

        // Misaligned load and store
        step("lw101", 1'b1, 4'h0, 3'd2, 32'h101, 32'h0, 1'b1, 1'b0);
        chk("lw101.mis", {31'h0, misaligned}, 32'h1);
        step("idle", 1'b0, 4'h0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("idle.mis", {31'h0, misaligned}, 32'h0);
        step("sh105", 1'b1, 4'h6, 3'd1, 32'h105, 32'hAAAA, 1'b1, 1'b0);
        chk("sh105.mis", {31'h0, misaligned}, 32'h1);
        step("lw104b", 1'b1, 4'h0, 3'd2, 32'h104, 32'h0, 1'b1, 1'b0);
        chk("lw104b.const", rdata, 32'h12345678);

        // Reset mid-operation with a store and stall: store dropped
        do_reset("rst_sw", 1'b1, 4'hF, 32'h100, 32'h55555555, 1'b1);
        step("lw100d", 1'b1, 4'h0, 3'd2, 32'h100, 32'h0, 1'b1, 1'b0);
        chk("lw100d.const", rdata, 32'h8001BEEF);

        // Raw pass-through, undefined funct3, address wrap
        step("lb_raw", 1'b1, 4'h0, 3'd0, 32'h103, 32'h0, 1'b0, 1'b0);
        chk("lb_raw.const", rdata, 32'h8001BEEF);
        step("undef", 1'b1, 4'h0, 3'd3, 32'h100, 32'h0, 1'b1, 1'b0);
        chk("undef.const", rdata, 32'h0);
        step("wrap", 1'b1, 4'h0, 3'd2, 32'hABCD0100, 32'h0, 1'b1, 1'b0);
        chk("wrap.const", rdata, 32'h8001BEEF);

        // Random traffic inside a 16-word window, prefilled so every load is defined
        for (int i = 0; i < 16; i++)
            step("fill", 1'b1, 4'hF, 3'd2, 32'h200 + 32'(4 * i), $urandom(), 1'b1, 1'b0);
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            a = {r[31:16], 16'h0200 + 16'($urandom_range(0, 63))};
            d = $urandom();
            f3 = f3_tab[$urandom_range(0, 7)];
            if ($urandom_range(0, 1) == 0) w = 4'h0;
            else begin
                w = 4'($urandom_range(1, 15));
                f3 = 3'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 49) == 0)
                do_reset("rnd_rst", 1'b1, w, a, d, 1'(($urandom_range(0, 1))));
            else
                step("rnd", 1'($urandom_range(0, 9) != 0), w, f3, a, d,
                     1'($urandom_range(0, 6) != 0), 1'($urandom_range(0, 4) == 0));
        end
        // Read back the whole window
        for (int i = 0; i < 16; i++)
            step("rdback", 1'b1, 4'h0, 3'd2, 32'h200 + 32'(4 * i), 32'h0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ama_riscv_dmem_resp.md
# ama_riscv_dmem_resp

Data-memory responder for the EX→MEM boundary of the ama_riscv pipeline: the memory-side counterpart of the control unit's `dmem_en` / byte-write-mask (`dmem_we`) request signals. It owns a synchronous, byte-writable word array and performs stores in the cycle of the request. For loads, it returns data one cycle later, shifted to bit 0 and sign- or zero-extended per funct3, ready for writeback mux selection. It also flags misaligned accesses and honours pipeline stalls.

## Interface
- `ADDR_W`, 14: word-address width; array holds 2^ADDR_W 32-bit words.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `stall`  in  1: pipeline stall; when 1, no array access and all output registers hold.
- `en`  in  1: access request (driven from control `dmem_en`).
- `we`  in  4: byte-lane write enables (control `dmem_we`); all-zero with `en`=1 means load.
- `load_sm_en`  in  1: load shift/mask enable; 1 = apply alignment/extension, 0 = pass raw word.
- `funct3`  in  3: access width/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010).
- `addr`  in  32: byte address; `addr[1:0]` = lane offset, `addr[ADDR_W+1:2]` = word index, upper bits ignored.
- `wdata`  in  32: store data, unshifted (value in low bits, as read from rs2).
- `rdata`  out  32: aligned, extended load data, valid in the cycle after the request.
- `rdata_raw`  out  32: unmodified word read, same timing as `rdata`.
- `misaligned`  out  1: one-cycle pulse, the cycle after a misaligned request.

## Operation
- Store (`en`=1, `we`≠0, not misaligned, `stall`=0): `wdata` shifted left by 8×`addr[1:0]`; each byte lane i written iff `we[i]`.
- Load (`en`=1, `we`=0, not misaligned, `stall`=0): word at index is read into an output register. `funct3` and `addr[1:0]` are registered alongside it.
- Load alignment, using the registered values:
  - byte: `rdata_raw >> 8×off`, bits [7:0], sign-extended (000) or zero-extended (100).
  - half: `rdata_raw >> 8×off`, bits [15:0], sign-extended (001) or zero-extended (101).
  - word: unchanged.
  - Undefined funct3 (011, 110, 111) yields `rdata`=0.
- `load_sm_en`=0 (registered): `rdata` = `rdata_raw`.
- Misalignment rules:
  - half with `addr[0]`=1, or word with `addr[1:0]`≠0, is misaligned.
  - Store is suppressed (no byte written).
  - Load output register is loaded with 0.
  - `misaligned`=1 next cycle.
- Out-of-range addresses wrap modulo 2^ADDR_W words; there is no error.
- `en`=0 with `stall`=0: output registers load 0 and `misaligned`=0, so stale data never reaches the pipeline.
- `we`≠0 with `en`=0: ignored.

## Timing
- Store: array updated at the rising edge ending the request cycle N; a load in cycle N+1 to the same word returns the new data in N+2.
- Load latency: exactly 1 cycle (request in N, `rdata` valid throughout N+1).
- Only one access per cycle. A store request produces no read, and `rdata`/`rdata_raw` load 0 the next cycle.
- `stall`=1: request ignored, and `rdata`, `rdata_raw`, `misaligned` and the registered funct3/offset/`load_sm_en` hold their values. A request held across stall cycles is serviced on the first non-stall cycle.
- Reset:
  - `rdata`=0, `rdata_raw`=0, `misaligned`=0, registered funct3/offset/`load_sm_en` = 0 the cycle after `rst`=1.
  - Array contents are not reset.
  - `rst` has priority over `stall`.
  - A request in the same cycle as `rst`=1 is dropped: no write.
- No combinational path from inputs to outputs.

## Test plan
- Word round-trip:
  - store `we`=1111, addr 0x100, wdata 0xDEADBEEF; then LW 0x100.
  - Required: `rdata`=0xDEADBEEF one cycle after the load request.
- Byte lanes and sign:
  - SB 0x80 to 0x103 (`we`=1000).
  - Required: LB 0x103 → 0xFFFFFF80, LBU 0x103 → 0x00000080, LW 0x100 → 0x80ADBEEF.
- Half-word:
  - SH 0x8001 at 0x102 (`we`=1100).
  - Required: LH 0x102 → 0xFFFF8001, LHU → 0x00008001.
- Misaligned:
  - LW 0x101.
  - Required: `rdata`=0 and `misaligned`=1 for one cycle.
  - SH at 0x105: word 0x104 unchanged, `misaligned` pulses.
- Stall hold:
  - LW 0x100 returns 0xDEADBEEF, then `stall`=1 for 3 cycles with new requests applied.
  - Required: `rdata` stays 0xDEADBEEF and no writes occur.
- Reset mid-operation:
  - assert `rst` in the same cycle as SW 0x55555555 to 0x100.
  - Required: outputs 0 the next cycle, and a subsequent LW 0x100 still returns the prior contents.
